systolic_mm_nxn: RTL
====================

// Module: systolic_mm_nxn
// PURPOSE
//  Parametrised NxN output-stationary systolic matrix multiplier computing C = A x B for square NxN operands.
//  The host streams N beats: column k of A and row k of B per beat. The block skews them internally, runs the PE mesh,
//  drains, then holds C on c_flat with done high. Sits between the operand buffer and the result writeback.
// PARAMETERS
//  N       4                  array dimension and inner-product depth (N >= 2)
//  DW      8                  operand element width
//  ACC_W   2*DW+$clog2(N)     accumulator/result element width
//  SIGNED  0                  0 = unsigned operands, 1 = two's-complement operands and results
// PORTS
//  clk       in   1         clock, rising edge
//  rst       in   1         asynchronous, active-low reset
//  start     in   1         begin new multiply; sampled only in IDLE
//  in_valid  in   1         a_col/b_row carry a beat
//  in_ready  out  1         beat accepted when in_valid && in_ready
//  a_col     in   N*DW      A[i][k] at bits [i*DW +: DW]
//  b_row     in   N*DW      B[k][j] at bits [j*DW +: DW]
//  busy      out  1         high in LOAD and DRAIN
//  done      out  1         level; high from completion until the next accepted start
//  c_flat    out  N*N*ACC_W C[i][j] at bits [(i*N+j)*ACC_W +: ACC_W]
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; every PE accumulator and pass register 0; skew lines 0; beat/drain counters 0.
//  FSM:
//   - IDLE -(start)-> LOAD. Entry into LOAD clears all accumulators in the same edge and drops done.
//   - LOAD: in_ready=1. Count accepted beats. The N-th accepted beat moves the FSM to DRAIN.
//   - DRAIN: in_ready=0. Runs exactly 2N-1 cycles counted from the edge that accepted the last beat,
//     then -> IDLE with done=1.
//   - done stays high and c_flat is frozen until the next start.
//  Skew:
//   - Row i of A passes a delay line of i registers; column j of B passes a delay line of j registers.
//   - Any cycle without an accepted beat (bubble, or any cycle outside LOAD) injects 0 into every lane.
//   - Bubbles are therefore legal in LOAD and add 0 to every accumulator; they lengthen LOAD only.
//  PE(i,j): registers a rightward and b downward, and does acc <= acc + a*b every cycle while busy.
//   - Product width is 2*DW, sign- or zero-extended to ACC_W per SIGNED.
//   - The sum wraps modulo 2^ACC_W with no saturation and no flag.
//  Latency, no bubbles: start at edge 0 -> beats at edges 1..N -> done rises at edge N+2N-1 = 3N-1.
//   c_flat is valid on the cycle done is first high.
//  Boundaries:
//   - start while busy: ignored.
//   - start in IDLE with done high: new run, done drops.
//   - in_valid outside LOAD: ignored and not consumed.
//   - start and in_valid in the same IDLE cycle: that beat is NOT accepted (in_ready=0 in IDLE).
//   - rst low mid-run: immediate abort to reset state; no partial done.
//  c_flat is driven straight from the accumulators. During busy it shows partial sums and must not be
//  sampled; only done qualifies it.
// STRUCTURE
//  - systolic_pkg: FSM state enum {IDLE, LOAD, DRAIN}; counter width localparams derived from N.
//  - Sub-module systolic_pe: ports clk, rst, clr, en, a_in, b_in, a_out, b_out, acc.
//    Parametrised by DW, ACC_W, SIGNED. Instantiated NxN via generate.
//  - Top level holds the FSM, the beat and drain counters, the skew delay lines and the c_flat packing.
// TESTING
//  1. N=2, A=[[1,2],[3,4]], B=I, no bubbles -> C=[[1,2],[3,4]]; done rises exactly 5 cycles after start edge.
//  2. N=4, unsigned, all A=B=255 -> every C element = 260100 (fits ACC_W=18); in_ready high exactly 4 accepted beats.
//  3. N=4, SIGNED=1, all A=B=-128 -> every C = 65536.
//     Then A=-1, B=2 everywhere -> every C = -8 (0x3FFF8 in 18 bits).
//  4. N=4, in_valid toggled 1,0,0,1,0,1,1 -> same C as gap-free run; done delayed by exactly the 3 bubble cycles.
//  5. start pulsed during DRAIN and in_valid held high after LOAD -> no restart, no extra beats, C unchanged.
//  6. rst asserted mid-LOAD (after beat 2) -> busy/done/c_flat/in_ready = 0 same cycle.
//     A fresh run afterwards gives the correct C with no residue from the aborted run.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types for the NxN systolic multiplier: FSM state encoding and counter sizing helpers.
// Counter widths are functions of N so each instance sizes its own beat/drain counters.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Beat counter holds 0..N-1.
  function automatic int beat_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Drain counter holds 0..2N-2.
  function automatic int drain_cnt_w(input int n);
    return (n > 1) ? $clog2(2 * n - 1) : 1;
  endfunction

endpackage

// File: rtl/systolic_mm_nxn_if.sv
// Host-side bundle of the systolic multiplier: start/beat handshake, status and the packed result.
interface systolic_mm_nxn_if #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 2 * DW + $clog2(N)
);

  logic                   start;
  logic                   in_valid;
  logic                   in_ready;
  logic [N*DW-1:0]        a_col;
  logic [N*DW-1:0]        b_row;
  logic                   busy;
  logic                   done;
  logic [N*N*ACC_W-1:0]   c_flat;

  modport master (
    output start, in_valid, a_col, b_row,
    input  in_ready, busy, done, c_flat
  );

  modport slave (
    input  start, in_valid, a_col, b_row,
    output in_ready, busy, done, c_flat
  );

endinterface

// File: rtl/systolic_pe.sv
// One mesh cell: forwards a right and b down through a register each and accumulates a*b while enabled.
// clr wins over en so a new run starts from zero regardless of the enable.
module systolic_pe #(
  parameter int DW     = 8,
  parameter int ACC_W  = 18,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    a_in,
  input  logic [DW-1:0]    b_in,
  output logic [DW-1:0]    a_out,
  output logic [DW-1:0]    b_out,
  output logic [ACC_W-1:0] acc
);

  logic [DW-1:0]    a_q, a_d;
  logic [DW-1:0]    b_q, b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] prod_ext;

  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [2*DW-1:0] prod_s;
      // Low 2*DW bits of the widened product are exact for any DW x DW signed pair.
      assign prod_s   = $signed({{DW{a_in[DW-1]}}, a_in}) * $signed({{DW{b_in[DW-1]}}, b_in});
      assign prod_ext = {{(ACC_W - 2 * DW){prod_s[2*DW-1]}}, prod_s};
    end else begin : g_unsigned
      logic [2*DW-1:0] prod_u;
      assign prod_u   = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};
      assign prod_ext = {{(ACC_W - 2 * DW){1'b0}}, prod_u};
    end
  endgenerate

  always_comb begin
    a_d   = a_in;
    b_d   = b_in;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_mm_nxn.sv
// Output-stationary NxN matrix multiplier: N operand beats in, done 2N-1 cycles after the last beat.
// in_ready is high only in LOAD; bubbles are allowed there and simply stretch the load phase.
module systolic_mm_nxn
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int ACC_W  = 2 * DW + $clog2(N),
  parameter int SIGNED = 0
) (
  input logic              clk,
  input logic              rst,
  systolic_mm_nxn_if.slave io
);

  localparam int BEAT_W  = beat_cnt_w(N);
  localparam int DRAIN_W = drain_cnt_w(N);

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               done_q, done_d;
  logic               clr;
  logic               accept;
  logic               busy;

  assign accept = (state_q == LOAD) && io.in_valid;
  assign busy   = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    done_d  = done_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          state_d = LOAD;
          clr     = 1'b1;
          done_d  = 1'b0;
          beat_d  = '0;
          drain_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (beat_q == BEAT_W'(N - 1)) begin
            state_d = DRAIN;
            beat_d  = '0;
            drain_d = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      DRAIN: begin
        // The last product reaches PE(N-1,N-1) 2N-2 edges after the final beat; one more edge settles it.
        if (drain_q == DRAIN_W'(2 * N - 2)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          drain_d = '0;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  assign io.in_ready = (state_q == LOAD);
  assign io.busy     = busy;
  assign io.done     = done_q;

  // a_h[i][j] / b_v[i][j] are the operand inputs of PE(i,j).
  logic [DW-1:0] a_h [N][N];
  logic [DW-1:0] b_v [N][N];

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_skew
      logic [DW-1:0] a_lane, b_lane;
      assign a_lane = accept ? io.a_col[gi*DW +: DW] : '0;
      assign b_lane = accept ? io.b_row[gi*DW +: DW] : '0;

      if (gi == 0) begin : g_direct
        assign a_h[0][0] = a_lane;
        assign b_v[0][0] = b_lane;
      end else begin : g_dly
        logic [DW-1:0] a_line_q [gi];
        logic [DW-1:0] a_line_d [gi];
        logic [DW-1:0] b_line_q [gi];
        logic [DW-1:0] b_line_d [gi];

        always_comb begin
          a_line_d[0] = a_lane;
          b_line_d[0] = b_lane;
          for (int s = 1; s < gi; s++) begin
            a_line_d[s] = a_line_q[s-1];
            b_line_d[s] = b_line_q[s-1];
          end
        end

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            for (int s = 0; s < gi; s++) begin
              a_line_q[s] <= '0;
              b_line_q[s] <= '0;
            end
          end else begin
            for (int s = 0; s < gi; s++) begin
              a_line_q[s] <= a_line_d[s];
              b_line_q[s] <= b_line_d[s];
            end
          end
        end

        assign a_h[gi][0] = a_line_q[gi-1];
        assign b_v[0][gi] = b_line_q[gi-1];
      end
    end

    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        logic [DW-1:0]    a_o, b_o;
        logic [ACC_W-1:0] acc;

        systolic_pe #(
          .DW     (DW),
          .ACC_W  (ACC_W),
          .SIGNED (SIGNED)
        ) u_pe (
          .clk   (clk),
          .rst   (rst),
          .clr   (clr),
          .en    (busy),
          .a_in  (a_h[gi][gj]),
          .b_in  (b_v[gi][gj]),
          .a_out (a_o),
          .b_out (b_o),
          .acc   (acc)
        );

        if (gj < N - 1) begin : g_a_fwd
          assign a_h[gi][gj+1] = a_o;
        end else begin : g_a_edge
          logic [DW-1:0] a_unused;
          assign a_unused = a_o;
        end

        if (gi < N - 1) begin : g_b_fwd
          assign b_v[gi+1][gj] = b_o;
        end else begin : g_b_edge
          logic [DW-1:0] b_unused;
          assign b_unused = b_o;
        end

        assign io.c_flat[(gi*N+gj)*ACC_W +: ACC_W] = acc;
      end
    end
  endgenerate

endmodule
